// File: rtl/clk_fail_monitor_if.sv
// clk_fail_monitor_if: monitor control inputs and switch/status outputs
`timescale 1ns/1ps
interface clk_fail_monitor_if #(
    parameter int CNT_W = 8
);
    logic             clk_mon;
    logic             enable;
    logic             force_backup;
    logic             fail_clr;
    logic             switch_en;
    logic             mon_fail;
    logic             window_done;
    logic [CNT_W-1:0] edge_count;

    modport master (
        output clk_mon, enable, force_backup, fail_clr,
        input  switch_en, mon_fail, window_done, edge_count
    );

    modport slave (
        input  clk_mon, enable, force_backup, fail_clr,
        output switch_en, mon_fail, window_done, edge_count
    );
endinterface

// File: rtl/clk_fail_monitor.sv
// clk_fail_monitor: windowed edge counting of clk_mon with fail/recover hysteresis driving switch_en
`timescale 1ns/1ps
module clk_fail_monitor #(
    parameter int WINDOW          = 16,
    parameter int MIN_EDGES       = 2,
    parameter int FAIL_WINDOWS    = 2,
    parameter int RECOVER_WINDOWS = 4,
    parameter int CNT_W           = 8
) (
    input logic                clk,
    input logic                rst,
    clk_fail_monitor_if.slave  bus
);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int RUN_MAX = (FAIL_WINDOWS > RECOVER_WINDOWS) ? FAIL_WINDOWS : RECOVER_WINDOWS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    typedef enum logic [1:0] {PRIMARY, SUSPECT, BACKUP, RECOVER} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_edge_count;
    logic [CNT_W-1:0] w_sum;
    logic [RUN_W-1:0] r_bad_run;
    logic [RUN_W-1:0] r_good_run;
    logic [RUN_W-1:0] w_bad_nxt;
    logic [RUN_W-1:0] w_good_nxt;
    logic [RUN_W-1:0] w_bad_inc;
    logic [RUN_W-1:0] w_good_inc;
    logic             w_edge;
    logic             w_close;
    logic             w_good;
    logic             w_set_fail;
    logic             r_switch_en;
    logic             r_mon_fail;
    logic             r_window_done;

    assign w_edge     = r_s2 & ~r_s3;
    assign w_close    = bus.enable && (r_win_cnt == WIN_W'(WINDOW - 1));
    assign w_sum      = (&r_edge_cnt) ? r_edge_cnt : r_edge_cnt + CNT_W'(w_edge);
    assign w_good     = (w_sum >= CNT_W'(MIN_EDGES));
    assign w_bad_inc  = r_bad_run + RUN_W'(1);
    assign w_good_inc = r_good_run + RUN_W'(1);

    assign bus.switch_en   = r_switch_en;
    assign bus.mon_fail    = r_mon_fail;
    assign bus.window_done = r_window_done;
    assign bus.edge_count  = r_edge_count;

    // Hysteresis state machine: only a window close (or disable) can move state or run counters
    always_comb begin
        w_state_nxt = r_state;
        w_bad_nxt   = r_bad_run;
        w_good_nxt  = r_good_run;
        w_set_fail  = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = PRIMARY;
            w_bad_nxt   = '0;
            w_good_nxt  = '0;
        end else if (w_close) begin
            case (r_state)
                PRIMARY: begin
                    if (!w_good && FAIL_WINDOWS == 1) begin
                        w_state_nxt = BACKUP;
                        w_set_fail  = 1'b1;
                    end else if (!w_good) begin
                        w_state_nxt = SUSPECT;
                        w_bad_nxt   = RUN_W'(1);
                    end
                end
                SUSPECT: begin
                    if (w_good) begin
                        w_state_nxt = PRIMARY;
                        w_bad_nxt   = '0;
                    end else if (w_bad_inc == RUN_W'(FAIL_WINDOWS)) begin
                        w_state_nxt = BACKUP;
                        w_bad_nxt   = '0;
                        w_set_fail  = 1'b1;
                    end else begin
                        w_bad_nxt   = w_bad_inc;
                    end
                end
                BACKUP: begin
                    if (w_good && RECOVER_WINDOWS == 1) begin
                        w_state_nxt = PRIMARY;
                    end else if (w_good) begin
                        w_state_nxt = RECOVER;
                        w_good_nxt  = RUN_W'(1);
                    end
                end
                RECOVER: begin
                    if (!w_good) begin
                        w_state_nxt = BACKUP;
                        w_good_nxt  = '0;
                    end else if (w_good_inc == RUN_W'(RECOVER_WINDOWS)) begin
                        w_state_nxt = PRIMARY;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt  = w_good_inc;
                    end
                end
                default: w_state_nxt = PRIMARY;
            endcase
        end
    end

    // Synchronizer, window timing and edge counting; counters sit at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_s3          <= 1'b0;
            r_win_cnt     <= '0;
            r_edge_cnt    <= '0;
            r_edge_count  <= '0;
            r_window_done <= 1'b0;
        end else begin
            r_s1          <= bus.clk_mon;
            r_s2          <= r_s1;
            r_s3          <= r_s2;
            r_win_cnt     <= (!bus.enable || w_close) ? '0 : r_win_cnt + 1'b1;
            r_edge_cnt    <= (!bus.enable || w_close) ? '0 : w_sum;
            r_edge_count  <= w_close ? w_sum : r_edge_count;
            r_window_done <= w_close;
        end
    end

    // State register and registered outputs; a failover set beats a same-edge clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PRIMARY;
            r_bad_run   <= '0;
            r_good_run  <= '0;
            r_switch_en <= 1'b0;
            r_mon_fail  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bad_run   <= w_bad_nxt;
            r_good_run  <= w_good_nxt;
            r_switch_en <= (w_state_nxt == BACKUP) || (w_state_nxt == RECOVER) || bus.force_backup;
            r_mon_fail  <= w_set_fail || (r_mon_fail && !bus.fail_clr);
        end
    end
endmodule

// File: tb/tb_clk_fail_monitor.sv
// tb_clk_fail_monitor: directed scenarios with a per-window expectation queue checked at each window_done
`timescale 1ns/1ps
module tb_clk_fail_monitor;
    typedef struct {
        int   lo;
        int   hi;
        logic sw;
        logic mf;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   mon_clk = 1'b0;
    logic   mon_run = 1'b1;
    int     vectors = 0;
    int     fails = 0;
    exp_t   q[$];
    exp_t   m_e;

    clk_fail_monitor_if #(.CNT_W(8)) bus ();

    clk_fail_monitor #(
        .WINDOW(16), .MIN_EDGES(2), .FAIL_WINDOWS(2), .RECOVER_WINDOWS(4), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #2.5 clk = ~clk;
    always #10 mon_clk = ~mon_clk;
    assign bus.clk_mon = mon_clk & mon_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_win(input int lo, input int hi, input logic sw, input logic mf);
        q.push_back('{lo, hi, sw, mf});
    endtask

    task automatic wait_drain();
        int limit;
        limit = 20 * q.size() + 4;
        for (int i = 0; i < limit && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain_timeout_pending", q.size(), 0);
    endtask

    task automatic win(input int lo, input int hi, input logic sw, input logic mf);
        expect_win(lo, hi, sw, mf);
        wait_drain();
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.window_done === 1'b1) begin
            vectors++;
            assert ((q.size() != 0) === 1'b1) else begin
                fails++;
                $error("FAIL unexpected_window_done: observed pulse with %0d pending, expected a pending window", q.size());
            end
            if (q.size() != 0) begin
                m_e = q.pop_front();
                vectors++;
                assert ((bus.edge_count >= m_e.lo && bus.edge_count <= m_e.hi) === 1'b1) else begin
                    fails++;
                    $error("FAIL close_edge_count: observed %0d expected %0d..%0d", bus.edge_count, m_e.lo, m_e.hi);
                end
                chk("close_switch_en", bus.switch_en, m_e.sw);
                chk("close_mon_fail", bus.mon_fail, m_e.mf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected completion before 100us");
        $fatal(1);
    end

    initial begin
        bus.enable       = 1'b1;
        bus.force_backup = 1'b0;
        bus.fail_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_switch_en", bus.switch_en, 0);
        chk("rst_mon_fail", bus.mon_fail, 0);
        chk("rst_window_done", bus.window_done, 0);
        chk("rst_edge_count", bus.edge_count, 0);
        @(negedge clk);
        expect_win(3, 4, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("first_done_early", bus.window_done, 0);
        @(posedge clk);
        #1;
        chk("first_done_at_16", bus.window_done, 1);
        #1;
        wait_drain();
        win(4, 4, 1'b0, 1'b0);
        win(4, 4, 1'b0, 1'b0);
        mon_run = 1'b0;
        win(0, 1, 1'b0, 1'b0);
        mon_run = 1'b1;
        win(3, 5, 1'b0, 1'b0);
        win(4, 4, 1'b0, 1'b0);
        mon_run = 1'b0;
        win(0, 1, 1'b0, 1'b0);
        win(0, 0, 1'b1, 1'b1);
        win(0, 0, 1'b1, 1'b1);
        mon_run = 1'b1;
        win(3, 5, 1'b1, 1'b1);
        win(4, 4, 1'b1, 1'b1);
        mon_run = 1'b0;
        win(0, 1, 1'b1, 1'b1);
        mon_run = 1'b1;
        win(3, 5, 1'b1, 1'b1);
        win(4, 4, 1'b1, 1'b1);
        win(4, 4, 1'b1, 1'b1);
        win(4, 4, 1'b0, 1'b1);
        chk("mf_before_clr", bus.mon_fail, 1);
        @(negedge clk);
        bus.fail_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("mf_after_clr", bus.mon_fail, 0);
        bus.fail_clr = 1'b0;
        @(negedge clk);
        bus.force_backup = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("force_sw_high", bus.switch_en, 1);
        end
        @(negedge clk);
        bus.force_backup = 1'b0;
        @(posedge clk);
        #1;
        chk("force_release_sw", bus.switch_en, 0);
        win(4, 4, 1'b0, 1'b0);
        bus.enable = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("dis_window_done", bus.window_done, 0);
        chk("dis_edge_count_hold", bus.edge_count, 4);
        chk("dis_switch_en", bus.switch_en, 0);
        @(negedge clk);
        bus.force_backup = 1'b1;
        @(posedge clk);
        #1;
        chk("dis_force_sw", bus.switch_en, 1);
        @(negedge clk);
        bus.force_backup = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_release_sw", bus.switch_en, 0);
        @(negedge clk);
        expect_win(4, 4, 1'b0, 1'b0);
        bus.enable = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("en_done_early", bus.window_done, 0);
        @(posedge clk);
        #1;
        chk("en_done_at_16", bus.window_done, 1);
        #1;
        wait_drain();
        mon_run = 1'b0;
        win(0, 1, 1'b0, 1'b0);
        win(0, 0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #0.5;
        chk("async_rst_switch_en", bus.switch_en, 0);
        chk("async_rst_mon_fail", bus.mon_fail, 0);
        chk("async_rst_edge_count", bus.edge_count, 0);
        mon_run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_win(3, 5, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("rerst_done_early", bus.window_done, 0);
        @(posedge clk);
        #1;
        chk("rerst_done_at_16", bus.window_done, 1);
        #1;
        wait_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
